// File: rtl/uart_transceiver.sv
// UART transceiver: 1 start bit, PAYLOAD_BITS data bits LSB first, 1 stop bit, no parity.
// The RX input is synchronized and sampled at each bit's midpoint; TX holds each bit for CPB cycles.
module uart_transceiver #(
    parameter int CLK_HZ       = 27000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_txd,
    input  logic                    uart_tx_en,
    output logic                    uart_tx_busy,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  rx_state, rx_state_nxt;
    state_t                  tx_state, tx_state_nxt;
    logic                    rxd_meta, rxd_sync, rxd_prev;
    logic [CW-1:0]           rx_cnt, tx_cnt;
    logic [BW-1:0]           rx_bit, tx_bit;
    logic [PAYLOAD_BITS-1:0] rx_shift, tx_shift;
    logic                    rx_done;

    // Sync flops reset high so that leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= IDLE;
            tx_state <= IDLE;
        end else begin
            rx_state <= rx_state_nxt;
            tx_state <= tx_state_nxt;
        end
    end

    // Re-arm after STOP relies on the edge detector: a line held low never produces a new edge.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_done      = 1'b0;
        case (rx_state)
            IDLE:  if (rxd_prev && !rxd_sync) rx_state_nxt = START;
            START: if (rx_cnt == HALF_LAST) rx_state_nxt = rxd_sync ? IDLE : DATA;
            DATA:  if (rx_cnt == CNT_LAST && rx_bit == BIT_LAST) rx_state_nxt = STOP;
            STOP:  if (rx_cnt == CNT_LAST) begin
                rx_state_nxt = IDLE;
                rx_done      = 1'b1;
            end
            default: rx_state_nxt = IDLE;
        endcase
        if (!uart_rx_en) begin
            rx_state_nxt = IDLE;
            rx_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            if (!uart_rx_en || rx_state == IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else if (rx_state == START) begin
                rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
            end else if (rx_state == DATA) begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= rx_bit + 1'b1;
                    rx_shift <= {rxd_sync, rx_shift[PAYLOAD_BITS-1:1]};
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (rx_done) begin
                if (rxd_sync) begin
                    uart_rx_data  <= rx_shift;
                    uart_rx_valid <= 1'b1;
                end else if (rx_shift == '0) begin
                    uart_rx_break <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            IDLE:  if (uart_tx_en) tx_state_nxt = START;
            START: if (tx_cnt == CNT_LAST) tx_state_nxt = DATA;
            DATA:  if (tx_cnt == CNT_LAST && tx_bit == BIT_LAST) tx_state_nxt = STOP;
            STOP:  if (tx_cnt == CNT_LAST) tx_state_nxt = IDLE;
            default: tx_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (uart_tx_en) tx_shift <= uart_tx_data;
                end
                DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= tx_bit + 1'b1;
                        tx_shift <= tx_shift >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_cnt <= (tx_cnt == CNT_LAST) ? '0 : tx_cnt + 1'b1;
            endcase
        end
    end

    // Decoded from state so an async reset pulls the line high without waiting for a clock.
    always_comb begin
        uart_txd = 1'b1;
        case (tx_state)
            START:   uart_txd = 1'b0;
            DATA:    uart_txd = tx_shift[0];
            default: uart_txd = 1'b1;
        endcase
    end

    assign uart_tx_busy = (tx_state != IDLE);

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver at CPB=10: the stimulus queues expected frames and bytes,
// and independent TX and RX monitors pop and compare them as the DUT produces them.
module tb_uart_transceiver;

    typedef struct packed {
        logic       brk;
        logic [7:0] data;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       uart_tx_en = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;
    logic       uart_rxd, uart_txd, uart_tx_busy;
    logic       uart_rx_break, uart_rx_valid;
    logic [7:0] uart_rx_data;

    int total = 0;
    int bad = 0;

    rx_exp_t    rx_q[$];
    logic [9:0] tx_q[$];

    assign uart_rxd = loop ? uart_txd : rxd_drv;

    uart_transceiver #(
        .CLK_HZ(1000000),
        .BIT_RATE(100000),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_rxd(uart_rxd),
        .uart_rx_en(uart_rx_en),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data),
        .uart_txd(uart_txd),
        .uart_tx_en(uart_tx_en),
        .uart_tx_busy(uart_tx_busy),
        .uart_tx_data(uart_tx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame vector holds line levels in transmit order: bit 0 is the start bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    initial begin : tx_mon
        logic [9:0] f;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (uart_tx_busy && !reset) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_frame", 32'd1, 32'd0);
                    for (int k = 0; k < 200 && uart_tx_busy; k++) @(negedge clk);
                end else begin
                    f = tx_q.pop_front();
                    aborted = 1'b0;
                    for (int i = 0; i < 100; i++) begin
                        if (i > 0) @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        check("tx_bit", uart_txd, f[i/10]);
                        check("tx_busy_hold", uart_tx_busy, 1);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (!reset) check("tx_busy_fall", uart_tx_busy, 0);
                    end
                end
            end
        end
    end

    initial begin : rx_mon
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (uart_rx_valid || uart_rx_break) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_pulse", {uart_rx_break, uart_rx_valid}, 0);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_break_flag", uart_rx_break, e.brk);
                    check("rx_valid_flag", uart_rx_valid, !e.brk);
                    check("rx_data", uart_rx_data, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (uart_tx_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_timeout", n < 300, 1);
        uart_tx_en   = 1'b1;
        uart_tx_data = b;
        @(negedge clk);
        uart_tx_en   = 1'b0;
        uart_tx_data = ~b;
    endtask

    task automatic drive_rx(input logic [7:0] b);
        logic [9:0] f;
        f = frame_of(b);
        for (int i = 0; i < 10; i++) begin
            rxd_drv = f[i];
            repeat (10) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic wait_all(input int max);
        int n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || uart_tx_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < max, 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", uart_tx_busy, 0);
        check("rst_valid", uart_rx_valid, 0);
        check("rst_break", uart_rx_break, 0);
        check("rst_data", uart_rx_data, 0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xA5 on the line: 0,1,0,1,0,0,1,0,1,1; a request mid-frame is ignored
        tx_q.push_back(10'b11_0100_1010);
        send_byte(8'hA5);
        repeat (30) @(negedge clk);
        uart_tx_en = 1'b1;
        uart_tx_data = 8'h0F;
        @(negedge clk);
        uart_tx_en = 1'b0;
        wait_all(300);

        // Loopback, back-to-back frames
        loop = 1'b1;
        tx_q.push_back(frame_of(8'h3C));
        tx_q.push_back(frame_of(8'hFF));
        rx_q.push_back('{brk: 1'b0, data: 8'h3C});
        rx_q.push_back('{brk: 1'b0, data: 8'hFF});
        send_byte(8'h3C);
        send_byte(8'hFF);
        wait_all(400);
        loop = 1'b0;

        // Line held low for 150 cycles: a single break, data keeps 0xFF
        rx_q.push_back('{brk: 1'b1, data: 8'hFF});
        rxd_drv = 1'b0;
        repeat (150) @(negedge clk);
        rxd_drv = 1'b1;
        wait_all(200);
        check("break_data_held", uart_rx_data, 8'hFF);

        // 3-cycle glitch: nothing reported
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_data_held", uart_rx_data, 8'hFF);

        // Receiver disabled, then enabled
        uart_rx_en = 1'b0;
        drive_rx(8'h55);
        repeat (20) @(negedge clk);
        check("rx_dis_data_held", uart_rx_data, 8'hFF);
        uart_rx_en = 1'b1;
        repeat (5) @(negedge clk);
        rx_q.push_back('{brk: 1'b0, data: 8'h55});
        drive_rx(8'h55);
        wait_all(200);
        check("rx_en_data", uart_rx_data, 8'h55);

        // Reset 45 cycles into a frame, then a clean frame over loopback
        tx_q.push_back(frame_of(8'h96));
        send_byte(8'h96);
        repeat (44) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_txd", uart_txd, 1);
        check("midrst_busy", uart_tx_busy, 0);
        repeat (3) @(negedge clk);
        check("midrst_rx_data", uart_rx_data, 0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_qempty", tx_q.size(), 0);
        loop = 1'b1;
        tx_q.push_back(frame_of(8'hC3));
        rx_q.push_back('{brk: 1'b0, data: 8'hC3});
        send_byte(8'hC3);
        wait_all(300);
        loop = 1'b0;

        check("final_rx_q", rx_q.size(), 0);
        check("final_tx_q", tx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600: serial bit rate in bit/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8: data bits per frame.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port uart_rxd, input, 1: serial receive line, asynchronous to clk, idle high.
REQ-007 SHALL have port uart_rx_en, input, 1: receiver enable.
REQ-008 SHALL have port uart_rx_break, output, 1: one-cycle pulse when a BREAK frame is received.
REQ-009 SHALL have port uart_rx_valid, output, 1: one-cycle pulse when uart_rx_data holds a new valid byte.
REQ-010 SHALL have port uart_rx_data, output, PAYLOAD_BITS: last received payload.
REQ-011 SHALL have port uart_txd, output, 1: serial transmit line, idle high.
REQ-012 SHALL have port uart_tx_en, input, 1: transmit request, sampled each cycle.
REQ-013 SHALL have port uart_tx_busy, output, 1: high while a frame is being sent.
REQ-014 SHALL have port uart_tx_data, input, PAYLOAD_BITS: payload to send.

Function
REQ-015 SHALL use CPB = CLK_HZ / BIT_RATE clock cycles per bit (integer division; 2812 at defaults).
REQ-016 SHALL use frame format 8N1 generalized: 1 start bit (0), PAYLOAD_BITS data bits LSB first, 1 stop bit (1), no parity.
REQ-017 RX SHALL pass uart_rxd through a 2-flop synchronizer before any use.
REQ-018 RX FSM states SHALL be IDLE, START, DATA, STOP; IDLE waits for a synchronized high-to-low transition while uart_rx_en=1.
REQ-019 RX SHALL sample each bit at its midpoint (CPB/2 cycles into the start bit, then every CPB cycles).
REQ-020 RX SHALL return to IDLE without any output if the start bit is high at its midpoint (glitch rejection).
REQ-021 On stop bit high, RX SHALL update uart_rx_data and pulse uart_rx_valid for exactly one cycle.
REQ-022 On stop bit low with all data bits 0, RX SHALL pulse uart_rx_break for one cycle, leave uart_rx_data unchanged, and not assert uart_rx_valid.
REQ-023 On stop bit low with any data bit 1 (framing error), RX SHALL discard the frame silently.
REQ-024 After STOP, RX SHALL re-arm only once the synchronized line is high, so a held-low line yields one break pulse only.
REQ-025 uart_rx_en=0 SHALL force RX to IDLE immediately, aborting any frame in progress.
REQ-026 uart_rx_data SHALL hold its value between frames.
REQ-027 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-028 In IDLE with uart_tx_en=1, TX SHALL latch uart_tx_data, and on the next cycle drive uart_txd=0 and uart_tx_busy=1.
REQ-029 TX SHALL hold each bit for exactly CPB cycles; a frame SHALL last (PAYLOAD_BITS+2)*CPB cycles.
REQ-030 uart_tx_busy SHALL fall on the cycle after the stop bit's last cycle; a new uart_tx_en may then start the next frame with no extra idle gap.
REQ-031 uart_tx_en while uart_tx_busy=1 SHALL be ignored; changes to uart_tx_data mid-frame SHALL not affect the frame.
REQ-032 RX and TX SHALL operate fully independently, with simultaneous receive and transmit supported.

Reset
REQ-033 While reset=1: both FSMs IDLE, all counters 0, uart_txd=1, uart_tx_busy=0, uart_rx_valid=0, uart_rx_break=0, uart_rx_data=0, synchronizer flops=1.
REQ-034 Reset mid-frame SHALL abort immediately; uart_txd returns high asynchronously and no partial byte is reported.

Verification (CLK_HZ=1000000, BIT_RATE=100000, so CPB=10)
REQ-035 Send 0xA5 on uart_tx_data with a 1-cycle uart_tx_en -> uart_txd = 0,1,0,1,0,0,1,0,1,1 (10 cycles per bit); busy high for exactly 100 cycles.
REQ-036 Loop uart_txd to uart_rxd and send 0x3C then 0xFF back-to-back -> two uart_rx_valid pulses with data 0x3C then 0xFF; no break pulse.
REQ-037 Hold uart_rxd low for 150 cycles, then high -> exactly one uart_rx_break pulse; uart_rx_valid stays 0; uart_rx_data unchanged.
REQ-038 Drive a 3-cycle low glitch on idle uart_rxd -> no valid or break pulse; RX back in IDLE.
REQ-039 Assert reset 45 cycles into a TX frame -> uart_txd=1 and busy=0 immediately; the next request sends a complete, correct frame.
REQ-040 Feed 0x55 with uart_rx_en=0 -> no valid pulse; with uart_rx_en=1 -> valid pulse with 0x55.
